ws2812_rx: RTL
==============

WS2812_RX -- requirements
Module: ws2812_rx

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning the number of input synchronizer flops (2..4).
REQ-002 SHALL have port clk_in  input  1  the system clock; the only clock in the block.
REQ-003 SHALL have port rst_n_in  input  1  reset, asynchronous assert, active low.
REQ-004 SHALL have port ws2812_data_in  input  1  the asynchronous WS2812 one-wire line.
REQ-005 SHALL have port t_thr_cnt_in  input  8  the high-time threshold in clk_in cycles; at or above it the bit decodes as 1, below it as 0.
REQ-006 SHALL have port t_min_cnt_in  input  8  the minimum legal high time in clk_in cycles.
REQ-007 SHALL have port rst_cnt_in  input  8  the frame-reset low time, in units of 256 clk_in cycles.
REQ-008 SHALL have port byte_rdy_out  output  1  a one-cycle strobe marking byte_data_out valid.
REQ-009 SHALL have port byte_data_out  output  8  the decoded byte, MSB received first.
REQ-010 SHALL have port frame_rdy_out  output  1  a one-cycle strobe at the end of a frame.
REQ-011 SHALL have port err_out  output  1  a one-cycle strobe on a protocol error.

Function
REQ-012 SHALL pass ws2812_data_in through SYNC_STAGES flops, then one edge-detect flop; all decoding SHALL use only the synchronized signal.
REQ-013 SHALL implement the states SYNC, IDLE, HIGH and LOW.
REQ-014 SYNC: SHALL ignore all pulses; a synchronized low lasting at least rst_cnt_in*256 cycles SHALL move the block to IDLE.
REQ-015 IDLE: a synchronized rising edge SHALL clear high_cnt and move the block to HIGH.
REQ-016 HIGH: high_cnt SHALL increment every cycle, saturating at 255.
REQ-017 HIGH, falling edge: SHALL shift in bit = (high_cnt >= t_thr_cnt_in), clear low_cnt and go to LOW.
REQ-018 HIGH, saturation: high_cnt reaching 255 SHALL cause an error; the partial byte SHALL be discarded and the block SHALL go to SYNC.
REQ-019 LOW: low_cnt (16 bit) SHALL increment every cycle, saturating at 16'hFFFF.
REQ-020 LOW, rising edge: SHALL clear high_cnt and go to HIGH.
REQ-021 LOW, low_cnt reaching {rst_cnt_in,8'h00}: SHALL end the frame and go to IDLE.
REQ-022 A falling edge with high_cnt < t_min_cnt_in SHALL be treated as a glitch: no bit shifted, error raised, state to SYNC.
REQ-023 The 8th shifted bit SHALL drive byte_rdy_out high for exactly one cycle; byte_data_out SHALL update in the same cycle and hold until the next byte.
REQ-024 Latency from a falling edge on ws2812_data_in to byte_rdy_out SHALL be SYNC_STAGES+1 clk_in cycles.
REQ-025 At frame end, frame_rdy_out SHALL pulse for one cycle only if at least one complete byte was received since the last frame end.
REQ-026 At frame end, a nonzero partial bit count SHALL be discarded and SHALL raise an error in the same cycle as frame_rdy_out.
REQ-027 The bit counter SHALL wrap from 7 to 0 on byte completion; frames SHALL have no length limit.
REQ-028 rst_cnt_in = 0 SHALL be treated as 1 (256 cycles).
REQ-029 Config inputs SHALL be sampled live; a change mid-frame SHALL take effect from the next comparison.
REQ-030 If a falling edge and a counter saturation occur in the same cycle, the falling edge SHALL take priority.

Reset
REQ-031 On rst_n_in low: state=SYNC, all counters 0, shift register 0, all outputs 0, synchronizer flops 0.
REQ-032 Reset asserted mid-byte SHALL discard the partial byte with no strobe on any output.
REQ-033 After reset release, the first valid frame SHALL be decoded only after a full reset-low period.

Configuration
REQ-034 The macro WS2812_RX_ERR_EN SHALL control error detection.
REQ-035 With WS2812_RX_ERR_EN defined: err_out SHALL be driven per REQ-018, REQ-022 and REQ-026.
REQ-036 Without WS2812_RX_ERR_EN: err_out SHALL be tied 0 and the t_min_cnt_in check removed (input unused); glitches SHALL decode as 0 bits, and saturation SHALL still force SYNC.

Verification
Common settings: thr=42, min=8, rst_cnt=16 (4096 cycles).
REQ-037 Reset, then 5000 low cycles, then byte 0xA5 (T1H=56/T1L=40, T0H=28/T0L=68) -> byte_rdy_out pulse with 0xA5, SYNC_STAGES+1 cycles after the 8th falling edge.
REQ-038 3 bytes 0x00, 0xFF, 0x3C, then 4096 low cycles -> 3 byte strobes, then frame_rdy_out pulses once when low_cnt reaches 4096.
REQ-039 Frame of 12 bits then reset-low -> one byte strobe, then frame_rdy_out and err_out in the same cycle.
REQ-040 A 4-cycle high pulse mid-byte, WS2812_RX_ERR_EN defined -> err_out pulses, no byte strobe, then ignored until 4096 low cycles.
REQ-041 rst_n_in asserted after 5 bits, then released -> all outputs 0; pulses before a 4096-cycle low produce no strobes.
REQ-042 Line held high 300 cycles -> error at high_cnt=255, state SYNC, no byte_rdy_out.

Source files
------------

// File: rtl/ws2812_rx.sv
// rtl/ws2812_rx.sv - WS2812 one-wire receiver: synchronizer, pulse-width bit decoder, byte/frame strobes
// Optional macro WS2812_RX_ERR_EN enables glitch detection and err_out reporting.
module ws2812_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       ws2812_data_in,
  input  logic [7:0] t_thr_cnt_in,
  input  logic [7:0] t_min_cnt_in,
  input  logic [7:0] rst_cnt_in,
  output logic       byte_rdy_out,
  output logic [7:0] byte_data_out,
  output logic       frame_rdy_out,
  output logic       err_out
);

  typedef enum logic [1:0] {
    ST_SYNC = 2'd0,
    ST_IDLE = 2'd1,
    ST_HIGH = 2'd2,
    ST_LOW  = 2'd3
  } state_t;

`ifdef WS2812_RX_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   line;
  logic                   rise;
  logic                   fall;
  state_t                 state;
  logic [7:0]             high_cnt;
  logic [15:0]            low_cnt;
  logic [2:0]             bit_cnt;
  logic [7:0]             shift_q;
  logic                   byte_seen;
  logic [7:0]             rst_eff;
  logic [15:0]            rst_limit;
  logic                   glitch;
  logic                   bit_val;
  logic [7:0]             shift_next;

  assign line = sync_q[SYNC_STAGES-1];
  assign rise = line & ~prev_q;
  assign fall = ~line & prev_q;

  // A zero reset-time setting behaves as the smallest non-zero one.
  assign rst_eff    = (rst_cnt_in == 8'd0) ? 8'd1 : rst_cnt_in;
  assign rst_limit  = {rst_eff, 8'h00};
  assign bit_val    = (high_cnt >= t_thr_cnt_in);
  assign shift_next = {shift_q[6:0], bit_val};

`ifdef WS2812_RX_ERR_EN
  assign glitch = (high_cnt < t_min_cnt_in);
`else
  // Without error detection a short pulse simply decodes as a 0 bit.
  logic unused_t_min;
  assign unused_t_min = ^t_min_cnt_in;
  assign glitch       = 1'b0;
`endif

  // Synchronize the asynchronous line and keep one extra flop for edge detection.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], ws2812_data_in};
      prev_q <= line;
    end
  end

  // Decoder FSM: measures high/low times, shifts bits and raises registered strobes.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state         <= ST_SYNC;
      high_cnt      <= 8'd0;
      low_cnt       <= 16'd0;
      bit_cnt       <= 3'd0;
      shift_q       <= 8'd0;
      byte_seen     <= 1'b0;
      byte_rdy_out  <= 1'b0;
      byte_data_out <= 8'd0;
      frame_rdy_out <= 1'b0;
      err_out       <= 1'b0;
    end else begin
      byte_rdy_out  <= 1'b0;
      frame_rdy_out <= 1'b0;
      err_out       <= 1'b0;
      case (state)
        ST_SYNC: begin
          // Wait for one full reset-low period before trusting the line.
          if (line) begin
            low_cnt <= 16'd0;
          end else if (low_cnt >= rst_limit) begin
            low_cnt <= 16'd0;
            state   <= ST_IDLE;
          end else begin
            low_cnt <= low_cnt + 16'd1;
          end
        end
        ST_IDLE: begin
          if (rise) begin
            high_cnt <= 8'd0;
            state    <= ST_HIGH;
          end
        end
        ST_HIGH: begin
          // A falling edge wins over saturation in the same cycle.
          if (fall) begin
            if (glitch) begin
              err_out   <= ERR_EN;
              bit_cnt   <= 3'd0;
              shift_q   <= 8'd0;
              byte_seen <= 1'b0;
              low_cnt   <= 16'd0;
              state     <= ST_SYNC;
            end else begin
              shift_q <= shift_next;
              low_cnt <= 16'd0;
              state   <= ST_LOW;
              if (bit_cnt == 3'd7) begin
                byte_data_out <= shift_next;
                byte_rdy_out  <= 1'b1;
                byte_seen     <= 1'b1;
                bit_cnt       <= 3'd0;
              end else begin
                bit_cnt <= bit_cnt + 3'd1;
              end
            end
          end else if (high_cnt == 8'hFF) begin
            // Line stuck high: drop the partial byte and resynchronize.
            err_out   <= ERR_EN;
            bit_cnt   <= 3'd0;
            shift_q   <= 8'd0;
            byte_seen <= 1'b0;
            low_cnt   <= 16'd0;
            state     <= ST_SYNC;
          end else begin
            high_cnt <= high_cnt + 8'd1;
          end
        end
        ST_LOW: begin
          if (rise) begin
            high_cnt <= 8'd0;
            state    <= ST_HIGH;
          end else if (low_cnt >= rst_limit) begin
            // Frame end: report completed bytes, flag a dangling partial byte.
            frame_rdy_out <= byte_seen;
            err_out       <= ERR_EN & (bit_cnt != 3'd0);
            bit_cnt       <= 3'd0;
            shift_q       <= 8'd0;
            byte_seen     <= 1'b0;
            low_cnt       <= 16'd0;
            state         <= ST_IDLE;
          end else if (low_cnt != 16'hFFFF) begin
            low_cnt <= low_cnt + 16'd1;
          end
        end
        default: begin
          state <= ST_SYNC;
        end
      endcase
    end
  end

endmodule
